// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM fade controller.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } pwm_state_e;

    localparam int PWM_DUTY_W   = 4;
    localparam int PWM_PERIOD_W = 16;

endpackage

// File: rtl/pwm_step_timer.sv
// Step timer: counts enabled cycles and ticks on the last cycle of each period.
module pwm_step_timer
    import pwm_pkg::*;
#(
    parameter int PERIOD_W = PWM_PERIOD_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                tick_o
);

    logic [PERIOD_W-1:0] cnt_q;
    logic [PERIOD_W-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == period_i - 1'b1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fade controller; define PWM_FADE_BREATHE_EN to build the
// breathe mode that bounces between the start level and the target.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W   = PWM_DUTY_W,
    parameter int PERIOD_W = PWM_PERIOD_W
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Stop,
    input  logic [DUTY_W-1:0]   TargetDuty,
    input  logic [PERIOD_W-1:0] StepPeriod,
    input  logic                Breathe,
    output logic [DUTY_W-1:0]   DutyCycle,
    output logic                Busy,
    output logic                Done
);

    pwm_state_e          state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DUTY_W-1:0]   target_q, target_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                done_q, done_d;
`ifdef PWM_FADE_BREATHE_EN
    logic [DUTY_W-1:0]   origin_q, origin_d;
    logic                breathe_q, breathe_d;
`else
    logic                unused_breathe;
    assign unused_breathe = Breathe;
`endif

    logic                tick;
    logic                timer_clr;
    logic [PERIOD_W-1:0] eff_period;
    logic [DUTY_W-1:0]   step_val;

    // A latched period of zero behaves as one step per cycle.
    assign eff_period = (period_q == '0) ? PERIOD_W'(1) : period_q;
    assign step_val   = (duty_q < target_q) ? duty_q + 1'b1
                                            : duty_q - 1'b1;

    pwm_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .clear_i  (timer_clr),
        .enable_i (state_q == RAMP),
        .period_i (eff_period),
        .tick_o   (tick)
    );

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = target_q;
        period_d  = period_q;
        done_d    = 1'b0;
        timer_clr = 1'b0;
`ifdef PWM_FADE_BREATHE_EN
        origin_d  = origin_q;
        breathe_d = breathe_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Start && !Stop) begin
                    target_d  = TargetDuty;
                    period_d  = StepPeriod;
                    timer_clr = 1'b1;
`ifdef PWM_FADE_BREATHE_EN
                    origin_d  = duty_q;
                    breathe_d = Breathe;
`endif
                    if (TargetDuty != duty_q) begin
                        state_d = RAMP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (Stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    duty_d = step_val;
                    if (step_val == target_q) begin
`ifdef PWM_FADE_BREATHE_EN
                        if (breathe_q) begin
                            target_d = origin_q;
                            origin_d = target_q;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            target_q  <= '0;
            period_q  <= '0;
            done_q    <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
            origin_q  <= '0;
            breathe_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            target_q  <= target_d;
            period_q  <= period_d;
            done_q    <= done_d;
`ifdef PWM_FADE_BREATHE_EN
            origin_q  <= origin_d;
            breathe_q <= breathe_d;
`endif
        end
    end

    assign DutyCycle = duty_q;
    assign Busy      = (state_q == RAMP);
    assign Done      = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl; optional breathe section under PWM_FADE_BREATHE_EN.
module tb_pwm_fade_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, Stop, Breathe;
    logic [3:0]  TargetDuty;
    logic [15:0] StepPeriod;
    logic [3:0]  DutyCycle;
    logic        Busy, Done;

    int n_vec = 0;
    int n_err = 0;

    pwm_fade_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stop       (Stop),
        .TargetDuty (TargetDuty),
        .StepPeriod (StepPeriod),
        .Breathe    (Breathe),
        .DutyCycle  (DutyCycle),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 Clk = ~Clk;

    task automatic adv();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] d,
                        input logic b, input logic dn);
        chk({tag, ".duty"}, 32'(DutyCycle), 32'(d));
        chk({tag, ".busy"}, 32'(Busy), 32'(b));
        chk({tag, ".done"}, 32'(Done), 32'(dn));
    endtask

    // Pulse Start for one edge; afterwards we sit in cycle 1.
    task automatic kick(input logic [3:0] t, input logic [15:0] p,
                        input logic br);
        TargetDuty = t;
        StepPeriod = p;
        Breathe    = br;
        Start      = 1'b1;
        adv();
        Start      = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_d;
        Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Breathe = 1'b0;
        TargetDuty = '0; StepPeriod = '0;
        adv(); adv();
        Reset = 1'b0;
        adv();
        chk3("reset", 4'd0, 1'b0, 1'b0);

        // 0 -> 3, period 4: steps visible in cycles 5, 9, 13.
        kick(4'd3, 16'd4, 1'b0);
        for (int c = 1; c <= 13; c++) begin
            exp_d = (c >= 13) ? 4'd3 : (c >= 9) ? 4'd2 :
                    (c >= 5) ? 4'd1 : 4'd0;
            chk3($sformatf("up_c%0d", c), exp_d, c <= 12, c == 13);
            if (c < 13) adv();
        end
        adv();
        chk3("up_after", 4'd3, 1'b0, 1'b0);

        // 3 -> 0, period 0 acts as 1: Done in cycle 4.
        kick(4'd0, 16'd0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            chk3($sformatf("dn_c%0d", c), 4'(4 - c), c <= 3, c == 4);
            if (c < 4) adv();
        end

        // 0 -> 15, period 2; Stop lands on the tick that would give 7.
        kick(4'd15, 16'd2, 1'b0);
        for (int c = 1; c < 14; c++) adv();
        chk3("stop_pre", 4'd6, 1'b1, 1'b0);
        Stop = 1'b1;
        adv();
        Stop = 1'b0;
        chk3("stop_post", 4'd6, 1'b0, 1'b0);
        adv(); adv(); adv();
        chk3("stop_idle", 4'd6, 1'b0, 1'b0);

        // Start with target equal to the current level.
        kick(4'd6, 16'd3, 1'b0);
        chk3("eq_c1", 4'd6, 1'b0, 1'b1);
        adv();
        chk3("eq_c2", 4'd6, 1'b0, 1'b0);

        // 6 -> 8, period 3, second Start mid-ramp must be ignored.
        kick(4'd8, 16'd3, 1'b0);
        adv();
        kick(4'd0, 16'd1, 1'b0);
        chk3("ign_c3", 4'd6, 1'b1, 1'b0);
        adv();
        chk3("ign_c4", 4'd7, 1'b1, 1'b0);
        adv(); adv(); adv();
        chk3("ign_c7", 4'd8, 1'b0, 1'b1);

        // Reset mid-ramp at level 9.
        kick(4'd15, 16'd1, 1'b0);
        adv();
        chk3("rst_pre", 4'd9, 1'b1, 1'b0);
        Reset = 1'b1;
        adv();
        chk3("rst_post", 4'd0, 1'b0, 1'b0);
        Start = 1'b1; TargetDuty = 4'd5;
        adv();
        Start = 1'b0; Reset = 1'b0;
        chk3("rst_prio", 4'd0, 1'b0, 1'b0);

`ifdef PWM_FADE_BREATHE_EN
        kick(4'd2, 16'd1, 1'b0);
        adv(); adv();
        chk3("br_setup", 4'd2, 1'b0, 1'b1);
        kick(4'd5, 16'd1, 1'b1);
        chk3("br_c1", 4'd2, 1'b1, 1'b0);
        begin
            logic [3:0] seq [8];
            seq = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3, 4'd4};
            for (int i = 0; i < 8; i++) begin
                adv();
                chk3($sformatf("br_s%0d", i), seq[i], 1'b1, 1'b0);
            end
        end
        Stop = 1'b1;
        adv();
        Stop = 1'b0;
        chk3("br_stop", 4'd4, 1'b0, 1'b0);
`else
        // Breathe request has no effect in this build.
        kick(4'd2, 16'd1, 1'b1);
        adv(); adv();
        chk3("nobr_done", 4'd2, 1'b0, 1'b1);
        adv();
        chk3("nobr_idle", 4'd2, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
